// File: rtl/if_id_queue_pkg.sv
// Types and sizing shared by the fetch/decode instruction queue and its users.
`include "riscv_def.v"

package if_id_queue_pkg;

  localparam int XLEN_W = `XLEN;
  localparam int PC_W   = `PC_WIDTH;
  localparam int DEPTH  = `IFQ_DEPTH;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // One slot is stored as a single packed vector {pc, pcplus4, inst}.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pcplus4;
    logic [XLEN_W-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push and decode-side pop signals of the instruction queue.
interface if_id_queue_if;
  import if_id_queue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [PC_W-1:0]   in_pcplus4;
  logic [XLEN_W-1:0] in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_pcplus4;
  logic [XLEN_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  // master drives fetch/decode requests; slave is the queue itself.
  modport master (
    output in_valid, in_pc, in_pcplus4, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pcplus4, out_inst, count
  );

  modport slave (
    input  in_valid, in_pc, in_pcplus4, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pcplus4, out_inst, count
  );

endinterface

// File: rtl/riscv_def.v
// Shared RISC-V datapath widths and the instruction-queue depth.
`ifndef RISCV_DEF_V
`define RISCV_DEF_V

`define XLEN      32
`define PC_WIDTH  32
`define IFQ_DEPTH 4

`endif

// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode with first-word
// fall-through output and whole-queue flush on redirect.
module if_id_queue
  import if_id_queue_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  if_id_queue_if.slave ifq
);

  ifq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  ifq_entry_t       wr_entry, head;

  // in_ready looks only at occupancy, so decode back-pressure never
  // reaches fetch combinationally; a full queue refuses even when popping.
  assign ifq.in_ready  = (count_q != CNT_W'(DEPTH));
  assign ifq.out_valid = (count_q != '0);
  assign push          = ifq.in_valid  && ifq.in_ready;
  assign pop           = ifq.out_valid && ifq.out_ready;

  assign wr_entry = '{pc: ifq.in_pc, pcplus4: ifq.in_pcplus4, inst: ifq.in_inst};
  assign head     = mem_q[rd_ptr_q];

  assign ifq.out_pc      = head.pc;
  assign ifq.out_pcplus4 = head.pcplus4;
  assign ifq.out_inst    = head.inst;
  assign ifq.count       = count_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ifq.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is reset so the fall-through outputs read zero out of
  // reset; a flush deliberately leaves the contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !ifq.flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed table, corner sequences and
// a randomized run against a queue-based reference model.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  if_id_queue_if ifq ();

  if_id_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifq   (ifq.slave)
  );

  typedef struct {
    logic          v;
    logic          r;
    logic          f;
    logic [31:0]   pc;
    int            cnt;
    logic          ov;
    logic          ir;
    logic [31:0]   opc;
  } vec_t;

  ifq_entry_t model_q[$];

  function automatic logic [XLEN_W-1:0] inst_of(input logic [31:0] pc);
    return XLEN_W'(pc ^ 32'hA5A5_0013);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] pc);
    ifq.in_valid   = v;
    ifq.out_ready  = r;
    ifq.flush      = f;
    ifq.in_pc      = PC_W'(pc);
    ifq.in_pcplus4 = PC_W'(pc + 32'd4);
    ifq.in_inst    = inst_of(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".out_pc"},      64'(ifq.out_pc),      64'(pc));
    check({tag, ".out_pcplus4"}, 64'(ifq.out_pcplus4), 64'(pc + 32'd4));
    check({tag, ".out_inst"},    64'(ifq.out_inst),    64'(inst_of(pc)));
  endtask

  vec_t vecs[$];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    check("reset.count",     64'(ifq.count),       64'd0);
    check("reset.out_valid", 64'(ifq.out_valid),   64'd0);
    check("reset.in_ready",  64'(ifq.in_ready),    64'd1);
    check("reset.out_pc",    64'(ifq.out_pc),      64'd0);
    check("reset.out_inst",  64'(ifq.out_inst),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- directed table ----------------
    vecs.push_back('{1, 0, 0, 32'h0,   1, 1, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 32'h4,   2, 1, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 32'h8,   3, 1, 1, 32'h0});
    vecs.push_back('{1, 0, 0, 32'hC,   4, 1, 0, 32'h0});
    vecs.push_back('{1, 0, 0, 32'h10,  4, 1, 0, 32'h0});   // full: refused
    vecs.push_back('{1, 1, 0, 32'h10,  3, 1, 1, 32'h4});   // pop only
    vecs.push_back('{1, 1, 1, 32'h40,  0, 0, 1, 32'h0});   // flush wins
    vecs.push_back('{1, 0, 0, 32'h100, 1, 1, 1, 32'h100});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 0, 1, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0,   0, 0, 1, 32'h0});   // no underflow
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].pc);
      tick();
      check({tag, ".count"},     64'(ifq.count),     64'(vecs[i].cnt));
      check({tag, ".out_valid"}, 64'(ifq.out_valid), 64'(vecs[i].ov));
      check({tag, ".in_ready"},  64'(ifq.in_ready),  64'(vecs[i].ir));
      if (vecs[i].ov) check_head(tag, vecs[i].opc);
    end

    // ---------------- steady stream across pointer wrap ----------------
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check_head("stream.first", 32'h0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(4 * (k + 1)));
      tick();
      check("stream.count", 64'(ifq.count), 64'd1);
      check_head("stream", 32'(4 * (k + 1)));
    end

    // ---------------- async reset with two entries ----------------
    drive(1'b1, 1'b0, 1'b0, 32'h300);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("prereset.count", 64'(ifq.count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("areset.count",       64'(ifq.count),       64'd0);
    check("areset.out_valid",   64'(ifq.out_valid),   64'd0);
    check("areset.in_ready",    64'(ifq.in_ready),    64'd1);
    check("areset.out_pc",      64'(ifq.out_pc),      64'd0);
    check("areset.out_pcplus4", 64'(ifq.out_pcplus4), 64'd0);
    check("areset.out_inst",    64'(ifq.out_inst),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h200);
    tick();
    check("postreset.count", 64'(ifq.count), 64'd1);
    check_head("postreset", 32'h200);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    tick();

    // ---------------- randomized run vs reference queue ----------------
    model_q.delete();
    begin
      int unsigned seq = 0;
      for (int c = 0; c < 10000; c++) begin
        logic v, r, f;
        logic [31:0] pc;
        ifq_entry_t e;
        v  = ($urandom_range(0, 3) != 0);
        r  = ($urandom_range(0, 2) != 0);
        f  = ($urandom_range(0, 31) == 0);
        pc = 32'h1000 + 32'(seq * 4);
        drive(v, r, f, pc);
        ifq.in_inst = XLEN_W'($urandom);
        check("rand.count",     64'(ifq.count),     64'(model_q.size()));
        check("rand.out_valid", 64'(ifq.out_valid), 64'(model_q.size() != 0));
        check("rand.in_ready",  64'(ifq.in_ready),  64'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
          check("rand.out_pc",      64'(ifq.out_pc),      64'(model_q[0].pc));
          check("rand.out_pcplus4", 64'(ifq.out_pcplus4), 64'(model_q[0].pcplus4));
          check("rand.out_inst",    64'(ifq.out_inst),    64'(model_q[0].inst));
        end
        e = '{pc: ifq.in_pc, pcplus4: ifq.in_pcplus4, inst: ifq.in_inst};
        if (f) begin
          model_q.delete();
        end else begin
          bit can_push;
          can_push = v && (model_q.size() != DEPTH);
          if (r && model_q.size() != 0) void'(model_q.pop_front());
          if (can_push) begin
            model_q.push_back(e);
            seq++;
          end
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. It buffers up to DEPTH fetched instructions, each with its pc and pc+4, so that decode back-pressure does not stall the fetch stage combinationally. It also discards every wrong-path entry on a control-flow redirect. Fetch pushes into it; decode pops from it through a valid/ready handshake.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  queue can accept an entry this cycle.
- in_pc  in  `PC_WIDTH  pc of the fetched instruction.
- in_pcplus4  in  `PC_WIDTH  pc + 4 of the fetched instruction.
- in_inst  in  `XLEN  instruction word.
- flush  in  1  redirect (branch/jal/jalr taken); discard all contents.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head entry.
- out_pc  out  `PC_WIDTH  head entry pc.
- out_pcplus4  out  `PC_WIDTH  head entry pc + 4.
- out_inst  out  `XLEN  head entry instruction.
- count  out  $clog2(DEPTH)+1  current number of valid entries.

## Operation
- Circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. Occupancy is held in a separate count register.
- Push: in_valid && in_ready. The entry is written at wr_ptr, and wr_ptr increments.
- Pop: out_valid && out_ready. rd_ptr increments.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path from decode to fetch.
- out_valid = (count != 0). The out_* signals are driven directly from the entry at rd_ptr (first-word fall-through).
- Simultaneous push and pop when 0 < count < DEPTH: both occur, and count is unchanged.
- Full: push is blocked even if a pop occurs in the same cycle. The pop proceeds, and in_ready rises the next cycle.
- Empty: there is no bypass. A pushed entry becomes visible on the out_* ports only after the clock edge.
- Flush has the highest priority:
  - At the next edge, rd_ptr, wr_ptr and count all go to 0.
  - Any push or pop in the flush cycle is ignored; the push is treated as wrong-path and dropped.
  - Storage contents are not cleared.
- The out_* data signals are don't-care whenever out_valid = 0. The bench must not check them then.

## Timing
- Reset (rst_n low) values, applied asynchronously:
  - rd_ptr = wr_ptr = count = 0.
  - All storage entries = 0.
  - out_valid = 0, in_ready = 1, count = 0.
  - out_pc = out_pcplus4 = out_inst = 0.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- The first push is possible on the first rising edge after rst_n deasserts.
- Push-to-output latency is 1 cycle: an entry pushed at edge N drives out_valid high after edge N, provided the queue was empty.
- Throughput is one push and one pop per cycle in steady state. Sustained back-to-back operation runs with count in 1..DEPTH-1.
- After a flush at edge N:
  - out_valid = 0 and in_ready = 1 after edge N.
  - The correct-path instruction pushed at edge N+1 is visible after edge N+1.
- count updates only on clock edges. It never exceeds DEPTH and never underflows.

## Structure
- `XLEN and `PC_WIDTH come from riscv_def.v; include it and define no local widths.
- Add `IFQ_DEPTH (default 4) to riscv_def.v so that the top level and the bench share one value.
- No sub-module is needed: storage, pointers and count live in one module.
- The entry is packed as {pc, pcplus4, inst}, one vector per slot.

## Test plan
- Reset, then push pc 0x0, 0x4, 0x8 with out_ready=0:
  - count = 3, in_ready = 1.
  - out_pc = 0x0, out_pcplus4 = 0x4, out_inst = first word.
- Fill to DEPTH=4 with out_ready=0:
  - in_ready = 0, and a 5th push is not accepted.
  - Then set out_ready=1 for one cycle with in_valid=1: pop of pc 0x0 occurs, no push occurs, count = 3, in_ready = 1 the next cycle.
- Steady stream with in_valid=out_ready=1 for 20 cycles, starting with one entry in the queue:
  - count stays 1.
  - out_pc sequence is 0x0, 0x4, 0x8, … with no gaps, including across pointer wrap.
- Queue at count=3, assert flush together with in_valid=1 (pc 0x40) and out_ready=1:
  - Next cycle: count = 0, out_valid = 0.
  - Then push pc 0x100: out_pc = 0x100 one cycle later.
- Drop rst_n asynchronously between edges with count=2:
  - count = 0, out_valid = 0 and all out_* = 0 before the next edge.
  - After release, a normal push works.
- Random valid/ready/flush for 10k cycles against a reference queue model:
  - Every popped {pc, pcplus4, inst} matches the model.
  - No entry older than a flush is ever popped.
